icache: RTL

//   Direct-mapped, read-only instruction cache between the core fetch port and the memory bus.

---
 rtl/icache.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache.
// One-cycle hit path; line refill over a req/ack + beat-stream bus.
module icache #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_ena,
    input  logic [31:0] icache_addr,
    output logic        icache_valid,
    output logic [31:0] icache_data,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int WB  = $clog2(LINE_WORDS);
    localparam int IB  = $clog2(LINES);
    localparam int OFF = WB + 2;
    localparam int TW  = 32 - OFF - IB;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REQ,
        FILL,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [TW-1:0]    tag_ram  [LINES];
    logic [31:0]      data_ram [LINES*LINE_WORDS];
    logic [LINES-1:0] line_valid;

    logic [29:0]   req_word;
    logic [TW-1:0] tag_rd;
    logic [31:0]   word_rd;
    logic          kill;
    logic          flush_seen;
    logic [WB-1:0] beat_cnt;
    logic [31:0]   data_q;
    logic          valid_q;

    logic [TW-1:0]    a_tag;
    logic [IB-1:0]    a_idx;
    logic [WB-1:0]    a_off;
    logic [IB-1:0]    in_idx;
    logic [IB+WB-1:0] in_word;
    logic             hit;
    logic             accept;
    logic             beat;
    logic             last;
    logic             unused_addr;

    assign a_tag   = req_word[29:OFF+IB-2];
    assign a_idx   = req_word[OFF+IB-3:OFF-2];
    assign a_off   = req_word[WB-1:0];
    assign in_idx  = icache_addr[OFF+IB-1:OFF];
    assign in_word = icache_addr[OFF+IB-1:2];

    assign unused_addr = ^icache_addr[1:0];

    // A flush sampled with the request kills the hit for that request.
    assign hit = (state == LOOKUP) && line_valid[a_idx]
               && (tag_rd == a_tag) && !kill;

    assign accept = icache_ena
                  && ((state == IDLE) || (state == RESP) || hit);

    assign beat = (state == FILL) && mem_rvalid;
    assign last = (beat_cnt == WB'(LINE_WORDS - 1));

    assign mem_req      = (state == REQ);
    assign icache_valid = (state == LOOKUP) ? hit : valid_q;
    assign icache_data  = hit ? word_rd : data_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (!hit)        state_nx = REQ;
                else if (accept) state_nx = LOOKUP;
                else             state_nx = IDLE;
            end
            REQ: begin
                if (mem_ack) state_nx = FILL;
            end
            FILL: begin
                if (beat && last) state_nx = RESP;
            end
            RESP: begin
                state_nx = accept ? LOOKUP : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Tag/data arrays: synchronous read on accept, refill writes.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_rd  <= tag_ram[in_idx];
            word_rd <= data_ram[in_word];
        end
        if (beat) begin
            data_ram[{a_idx, beat_cnt}] <= mem_rdata;
            if (last) tag_ram[a_idx] <= a_tag;
        end
    end

    // Request latch, refill bookkeeping, output hold and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_word   <= '0;
            kill       <= 1'b0;
            flush_seen <= 1'b0;
            beat_cnt   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            mem_addr   <= '0;
            line_valid <= '0;
        end else begin
            if (accept) begin
                req_word <= icache_addr[31:2];
                kill     <= flush;
            end
            if (state == LOOKUP) begin
                valid_q <= hit;
                if (hit) begin
                    data_q <= word_rd;
                end else begin
                    mem_addr   <= {a_tag, a_idx, OFF'(0)};
                    flush_seen <= 1'b0;
                    beat_cnt   <= '0;
                end
            end else if ((state == REQ) || (state == FILL)) begin
                if (flush) flush_seen <= 1'b1;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + WB'(1);
                if (beat_cnt == a_off) data_q <= mem_rdata;
                if (last) valid_q <= 1'b1;
            end
            if (flush) begin
                line_valid <= '0;
            end else if (beat && last && !flush_seen) begin
                line_valid[a_idx] <= 1'b1;
            end
        end
    end

endmodule
